// File: rtl/intel_issp_reset_extend_pkg.sv
// Shared types for the ISSP-driven multi-channel reset generator.
// Channel FSM encoding and operating-mode selectors.
package intel_issp_reset_extend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_EXTEND
  } rst_state_t;

  localparam int MODE_LEVEL = 0;
  localparam int MODE_PULSE = 1;

endpackage

// File: rtl/intel_issp_reset_extend_chan.sv
// One ISSP reset channel: synchroniser, edge detect, FSM and hold counter.
// Output is a dedicated flop so consumers never see decode glitches.
module intel_issp_reset_extend_chan
  import intel_issp_reset_extend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int MODE        = MODE_LEVEL
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issp_i,
  output logic probe_o,
  output logic reset_o
);

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] HOLD = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
  (* async_reg = "true" *)
  logic [SYNC_STAGES-1:0] sync_q;

  logic          s;
  logic          s_d_q;
  logic          rise;
  rst_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rst_q, rst_d;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      s_d_q   <= 1'b0;
      state_q <= ST_EXTEND;
      cnt_q   <= HOLD;
      rst_q   <= 1'b1;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], issp_i};
      s_d_q   <= s;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (MODE == MODE_PULSE) begin
      // A rise restarts the count from any state, so retriggers stretch the pulse.
      if (rise) begin
        state_d = ST_EXTEND;
        cnt_d   = HOLD;
      end else if (state_q == ST_EXTEND) begin
        if (cnt_q == ONE) state_d = ST_IDLE;
        else              cnt_d   = cnt_q - ONE;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (s) state_d = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (!s) begin
            state_d = ST_EXTEND;
            cnt_d   = HOLD;
          end
        end
        ST_EXTEND: begin
          if (s)                 state_d = ST_ACTIVE;
          else if (cnt_q == ONE) state_d = ST_IDLE;
          else                   cnt_d   = cnt_q - ONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign rst_d   = (state_d != ST_IDLE);
  assign probe_o = s;
  assign reset_o = rst_q;

endmodule

// File: rtl/intel_issp_reset_extend.sv
// Multi-channel ISSP reset generator: stretches or pulses each ISSP bit
// into a registered active-high reset in the clk domain.
module intel_issp_reset_extend
  import intel_issp_reset_extend_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int HOLD_CYCLES  = 16,
  parameter int MODE         = MODE_LEVEL
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CHANNELS-1:0] issp_in,
  output logic [NUM_CHANNELS-1:0] reset_out,
  output logic [NUM_CHANNELS-1:0] probe_out
);

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    intel_issp_reset_extend_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .MODE        (MODE)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .issp_i  (issp_in[g]),
      .probe_o (probe_out[g]),
      .reset_o (reset_out[g])
    );
  end

endmodule

// File: tb/tb_intel_issp_reset_extend.sv
// Self-checking bench: directed vectors plus a cycle-level reference model
// across LEVEL, PULSE, HOLD_CYCLES=1 and HOLD_CYCLES=255 instances.
module tb_intel_issp_reset_extend;

  logic clk;
  logic rst_n = 1'b0;
  logic [3:0] lv_in = '0, pl_in = '0, h1_in = '0, hx_in = '0;
  logic [3:0] lv_rst, pl_rst, h1_rst, hx_rst;
  logic [3:0] lv_prb, pl_prb, h1_prb, hx_prb;

  int n_cmp = 0;
  int n_bad = 0;
  int ncyc  = 0;
  logic chk_en = 1'b0;
  logic [3:0] hist [4][4096];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  intel_issp_reset_extend #(.NUM_CHANNELS(4), .SYNC_STAGES(2),
    .HOLD_CYCLES(16), .MODE(0)) u_lv (
    .clk(clk), .rst_n(rst_n), .issp_in(lv_in),
    .reset_out(lv_rst), .probe_out(lv_prb));

  intel_issp_reset_extend #(.NUM_CHANNELS(4), .SYNC_STAGES(2),
    .HOLD_CYCLES(16), .MODE(1)) u_pl (
    .clk(clk), .rst_n(rst_n), .issp_in(pl_in),
    .reset_out(pl_rst), .probe_out(pl_prb));

  intel_issp_reset_extend #(.NUM_CHANNELS(4), .SYNC_STAGES(2),
    .HOLD_CYCLES(1), .MODE(0)) u_h1 (
    .clk(clk), .rst_n(rst_n), .issp_in(h1_in),
    .reset_out(h1_rst), .probe_out(h1_prb));

  intel_issp_reset_extend #(.NUM_CHANNELS(4), .SYNC_STAGES(2),
    .HOLD_CYCLES(255), .MODE(0)) u_hx (
    .clk(clk), .rst_n(rst_n), .issp_in(hx_in),
    .reset_out(hx_rst), .probe_out(hx_prb));

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Input sampled at edge m after reset release; before release it reads 0.
  function automatic logic [3:0] hin(input int d, input int m);
    if (m < 1 || m > ncyc) return 4'h0;
    return hist[d][m];
  endfunction

  // LEVEL: high if any input sample in [n-H-2, n-2] was 1.
  // PULSE: high if a rise (in[k-2] & ~in[k-3]) occurred at an edge in [n-H+1, n].
  function automatic logic [3:0] model(input int d);
    int hold;
    logic [3:0] r;
    hold = (d == 2) ? 1 : (d == 3) ? 255 : 16;
    r = (ncyc < hold) ? 4'hF : 4'h0;
    if (d == 1) begin
      for (int k = ncyc - hold + 1; k <= ncyc; k++)
        r |= hin(d, k - 2) & ~hin(d, k - 3);
    end else begin
      for (int k = ncyc - hold - 2; k <= ncyc - 2; k++)
        r |= hin(d, k);
    end
    return r;
  endfunction

  task automatic tick(input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] a2, input logic [3:0] a3);
    lv_in = a0; pl_in = a1; h1_in = a2; hx_in = a3;
    @(posedge clk);
    if (ncyc < 4095) ncyc++;
    hist[0][ncyc] = a0;
    hist[1][ncyc] = a1;
    hist[2][ncyc] = a2;
    hist[3][ncyc] = a3;
    #1;
    if (chk_en) begin
      check("mdl_lv_rst", lv_rst, model(0));
      check("mdl_pl_rst", pl_rst, model(1));
      check("mdl_h1_rst", h1_rst, model(2));
      check("mdl_hx_rst", hx_rst, model(3));
      check("mdl_lv_prb", lv_prb, hin(0, ncyc - 1));
      check("mdl_pl_prb", pl_prb, hin(1, ncyc - 1));
      check("mdl_h1_prb", h1_prb, hin(2, ncyc - 1));
      check("mdl_hx_prb", hx_prb, hin(3, ncyc - 1));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lv_in = '0; pl_in = '0; h1_in = '0; hx_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_lv_rst", lv_rst, 4'hF);
    check("rst_pl_rst", pl_rst, 4'hF);
    check("rst_hx_rst", hx_rst, 4'hF);
    check("rst_lv_prb", lv_prb, 4'h0);
    check("rst_h1_prb", h1_prb, 4'h0);
    @(negedge clk);
    rst_n  = 1'b1;
    ncyc   = 0;
    chk_en = 1'b1;
  endtask

  task automatic por_check();
    for (int i = 1; i <= 16; i++) begin
      tick(4'h0, 4'h0, 4'h0, 4'h0);
      if (i == 1)  check("por_h1_e1", h1_rst, 4'h0);
      if (i == 15) check("por_lv_e15", lv_rst, 4'hF);
      if (i == 16) check("por_lv_e16", lv_rst, 4'h0);
      if (i == 16) check("por_pl_e16", pl_rst, 4'h0);
      if (i == 16) check("por_hx_e16", hx_rst, 4'hF);
    end
  endtask

  initial begin
    int rise_j, fall_j, prb_j, hi_cnt;
    logic [3:0] r0, r1, r2, r3;

    // 1: power-on extension
    do_reset();
    por_check();
    repeat (260) tick(4'h0, 4'h0, 4'h0, 4'h0);
    check("por_hx_done", hx_rst, 4'h0);

    // 2: LEVEL hold on ch0 for 40 cycles
    rise_j = -1; fall_j = -1; prb_j = -1;
    for (int j = 0; j < 70; j++) begin
      tick({3'b0, logic'(j < 40)}, 4'h0, 4'h0, 4'h0);
      if (prb_j < 0 && lv_prb[0]) prb_j = j;
      if (rise_j < 0 && lv_rst[0]) rise_j = j;
      if (rise_j >= 0 && fall_j < 0 && !lv_rst[0]) fall_j = j;
    end
    check("lvl_prb_rise", prb_j, 1);
    check("lvl_rst_rise", rise_j, 2);
    check("lvl_rst_fall", fall_j, 58);

    // 3: LEVEL re-assert on ch1 after a 5-cycle gap
    rise_j = -1; fall_j = -1;
    for (int j = 0; j < 70; j++) begin
      tick({2'b0, logic'(j < 20 || (j >= 25 && j < 40)), 1'b0},
           4'h0, 4'h0, 4'h0);
      if (rise_j < 0 && lv_rst[1]) rise_j = j;
      if (rise_j >= 0 && fall_j < 0 && !lv_rst[1]) fall_j = j;
    end
    check("reas_rise", rise_j, 2);
    check("reas_fall", fall_j, 58);

    // 4: PULSE retrigger on ch2, then held high
    rise_j = -1; fall_j = -1; hi_cnt = 0;
    for (int j = 0; j < 60; j++) begin
      tick(4'h0, {1'b0, logic'(j < 4 || (j >= 8 && j < 50)), 2'b0},
           4'h0, 4'h0);
      if (pl_rst[2]) hi_cnt++;
      if (rise_j < 0 && pl_rst[2]) rise_j = j;
      if (rise_j >= 0 && fall_j < 0 && !pl_rst[2]) fall_j = j;
    end
    check("pls_rise", rise_j, 2);
    check("pls_fall", fall_j, 26);
    check("pls_hicnt", hi_cnt, 24);

    // 5: reset asserted mid-EXTEND on ch3 (cnt==3)
    for (int j = 0; j <= 20; j++)
      tick({logic'(j < 5), 3'b0}, 4'h0, 4'h0, 4'h0);
    check("mid_pre", lv_rst, 4'h8);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check("mid_async", lv_rst, 4'hF);
    do_reset();
    por_check();

    // 6: random toggling on all channels of all instances
    r0 = '0; r1 = '0; r2 = '0; r3 = '0;
    for (int j = 0; j < 400; j++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 6) == 0) r0[b] = ~r0[b];
        if ($urandom_range(0, 6) == 0) r1[b] = ~r1[b];
        if ($urandom_range(0, 4) == 0) r2[b] = ~r2[b];
        if ($urandom_range(0, 30) == 0) r3[b] = ~r3[b];
      end
      tick(r0, r1, r2, r3);
    end
    repeat (300) tick(4'h0, 4'h0, 4'h0, 4'h0);
    check("quiet_all", {lv_rst, pl_rst, h1_rst, hx_rst}, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
